// File: rtl/general_pack.sv
// general_pack: shared types and helpers for the Avalon-ST message framer.
//   framer_sm_t          - framer FSM state encoding (IDLE, IN_MSG)
//   empty_from_remaining - number of unused bytes in a beat carrying
//                          'remaining' bytes; 0 when the beat is full
package general_pack;

  typedef enum logic {IDLE, IN_MSG} framer_sm_t;

  function automatic int unsigned empty_from_remaining(
    input int unsigned remaining,
    input int unsigned bytes_per_beat
  );
    return (remaining >= bytes_per_beat) ? 0 : bytes_per_beat - remaining;
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// avalon_st_if: Avalon-ST beat bundle.
//   data/valid/sop/eop/empty driven by the master, rdy driven by the slave.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 16
);
  localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic                             valid;
  logic                             rdy;
  logic                             sop;
  logic                             eop;
  logic [EMPTY_W-1:0]               empty;

  modport master (output data, valid, sop, eop, empty, input rdy);
  modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_msg_framer_out_stage.sv
// avalon_st_out_stage: single Avalon-ST output register.
//   load/load_*  : new beat, only asserted when accept=1
//   accept       : register can take a beat this cycle (!valid | out_rdy)
//   out_*        : registered beat; all fields read 0 while out_valid=0
//   Bytes 0..load_empty-1 of the loaded data are zeroed.
//   rst: asynchronous, active-high.
module avalon_st_out_stage #(
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int EMPTY_W             = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
  input  logic [8*DATA_WIDTH_IN_BYTES-1:0] load_data,
  input  logic                             load_sop,
  input  logic                             load_eop,
  input  logic [EMPTY_W-1:0]               load_empty,
  input  logic                             out_rdy,
  output logic                             accept,
  output logic [8*DATA_WIDTH_IN_BYTES-1:0] out_data,
  output logic                             out_valid,
  output logic                             out_sop,
  output logic                             out_eop,
  output logic [EMPTY_W-1:0]               out_empty
);

  logic [8*DATA_WIDTH_IN_BYTES-1:0] masked;
  logic [8*DATA_WIDTH_IN_BYTES-1:0] data_q;
  logic                             valid_q;
  logic                             sop_q;
  logic                             eop_q;
  logic [EMPTY_W-1:0]               empty_q;

  assign accept = !valid_q || out_rdy;

  always_comb begin
    masked = load_data;
    for (int unsigned i = 0; i < DATA_WIDTH_IN_BYTES; i++) begin
      if (i < 32'(load_empty)) masked[i*8 +: 8] = '0;
    end
  end

  // A drain and a load in the same cycle keep valid high with the new beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      empty_q <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= masked;
      sop_q   <= load_sop;
      eop_q   <= load_eop;
      empty_q <= load_empty;
    end else if (out_rdy) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = valid_q ? data_q  : '0;
  assign out_sop   = valid_q & sop_q;
  assign out_eop   = valid_q & eop_q;
  assign out_empty = valid_q ? empty_q : '0;

endmodule

// File: rtl/avalon_msg_framer.sv
// avalon_msg_framer: frames an unframed word stream into Avalon-ST messages.
//   msg_len/len_valid/len_rdy   : per-message byte length
//   raw_data/raw_valid/raw_rdy  : payload words
//   framed_msg (master)         : sop/eop/empty-framed beats, invalid bytes zeroed
//   zero_len_error              : one-cycle pulse after a rejected zero length
//   busy                        : message in progress
//   msg_count (only with AVALON_FRAMER_MSG_COUNT_EN defined): eop handshakes seen
//   rst: asynchronous, active-high.
module avalon_msg_framer
  import general_pack::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int LEN_WIDTH           = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [LEN_WIDTH-1:0]             msg_len,
  input  logic                             len_valid,
  output logic                             len_rdy,
  input  logic [8*DATA_WIDTH_IN_BYTES-1:0] raw_data,
  input  logic                             raw_valid,
  output logic                             raw_rdy,
  avalon_st_if.master                      framed_msg,
  output logic                             zero_len_error,
  output logic                             busy
`ifdef AVALON_FRAMER_MSG_COUNT_EN
  ,
  output logic [31:0]                      msg_count
`endif
);

  localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;
  localparam logic [LEN_WIDTH-1:0] BEAT_BYTES = LEN_WIDTH'(DATA_WIDTH_IN_BYTES);

  framer_sm_t         state, state_nxt;
  logic [LEN_WIDTH-1:0] remaining;
  logic               first;
  logic               last;
  logic               len_accept;
  logic               zero_len;
  logic               raw_load;
  logic               stage_accept;
  logic [EMPTY_W-1:0] beat_empty;

  assign last       = (remaining <= BEAT_BYTES);
  assign beat_empty = EMPTY_W'(empty_from_remaining(32'(remaining), 32'(DATA_WIDTH_IN_BYTES)));

  always_comb begin
    state_nxt  = state;
    len_rdy    = 1'b0;
    raw_rdy    = 1'b0;
    busy       = 1'b0;
    len_accept = 1'b0;
    zero_len   = 1'b0;
    raw_load   = 1'b0;
    case (state)
      IDLE: begin
        len_rdy = !rst;
        if (len_valid) begin
          if (msg_len == '0) begin
            zero_len = 1'b1;
          end else begin
            len_accept = 1'b1;
            state_nxt  = IN_MSG;
          end
        end
      end
      IN_MSG: begin
        busy     = 1'b1;
        raw_rdy  = stage_accept;
        raw_load = raw_valid && stage_accept;
        if (raw_load && last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      remaining      <= '0;
      first          <= 1'b0;
      zero_len_error <= 1'b0;
    end else begin
      state          <= state_nxt;
      zero_len_error <= zero_len;
      if (len_accept) begin
        remaining <= msg_len;
        first     <= 1'b1;
      end else if (raw_load) begin
        first     <= 1'b0;
        remaining <= (remaining > BEAT_BYTES) ? remaining - BEAT_BYTES : '0;
      end
    end
  end

  logic [8*DATA_WIDTH_IN_BYTES-1:0] st_data;
  logic                             st_valid;
  logic                             st_sop;
  logic                             st_eop;
  logic [EMPTY_W-1:0]               st_empty;

  avalon_st_out_stage #(
    .DATA_WIDTH_IN_BYTES(DATA_WIDTH_IN_BYTES),
    .EMPTY_W            (EMPTY_W)
  ) u_out_stage (
    .clk       (clk),
    .rst       (rst),
    .load      (raw_load),
    .load_data (raw_data),
    .load_sop  (first),
    .load_eop  (last),
    .load_empty(beat_empty),
    .out_rdy   (framed_msg.rdy),
    .accept    (stage_accept),
    .out_data  (st_data),
    .out_valid (st_valid),
    .out_sop   (st_sop),
    .out_eop   (st_eop),
    .out_empty (st_empty)
  );

  assign framed_msg.data  = st_data;
  assign framed_msg.valid = st_valid;
  assign framed_msg.sop   = st_sop;
  assign framed_msg.eop   = st_eop;
  assign framed_msg.empty = st_empty;

`ifdef AVALON_FRAMER_MSG_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) msg_count <= '0;
    else if (st_valid && framed_msg.rdy && st_eop) msg_count <= msg_count + 32'd1;
  end
`endif

endmodule
